// File: rtl/iob_gpio_max_seq.sv
// Burst sequencer for the GPIO byte-maximum datapath: two-stage lane-max pipeline with index tracking.
// Define IOB_GPIO_MAX_SEQ_MIN_EN to add a parallel running-minimum output (min_o).
module iob_gpio_max_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        max_o,
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
  output logic [7:0]        min_o,
`endif
  output logic [CNT_W-1:0]  max_idx,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned Lanes = DATA_W / 8;
  localparam logic [CNT_W-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic [7:0]       max_q, max_d;
  logic [7:0]       s1_max_q, s1_max_d;
  logic             s1_valid_q, s1_valid_d;
  logic             done_q, done_d;
  logic [7:0]       lane_max;
  logic             hs;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
  logic [7:0]       min_q, min_d;
  logic [7:0]       s1_min_q, s1_min_d;
  logic [7:0]       lane_min;
`endif

  assign hs = (state_q == StRun) && in_valid;

  // Stage-1 reduction across the byte lanes of the incoming word.
  always_comb begin
    lane_max = '0;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    lane_min = 8'hFF;
`endif
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (in_data[8*i +: 8] > lane_max) lane_max = in_data[8*i +: 8];
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
      if (in_data[8*i +: 8] < lane_min) lane_min = in_data[8*i +: 8];
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    s1_max_d   = s1_max_q;
    s1_idx_d   = s1_idx_q;
    s1_valid_d = 1'b0;
    done_d     = 1'b0;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    min_d      = min_q;
    s1_min_d   = s1_min_q;
`endif

    // Stage 2: strictly-greater update keeps the earliest index on ties.
    if (s1_valid_q && (s1_max_q > max_q)) begin
      max_d     = s1_max_q;
      max_idx_d = s1_idx_q;
    end
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    if (s1_valid_q && (s1_min_q < min_q)) min_d = s1_min_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d     = len;
          count_d   = '0;
          max_d     = '0;
          max_idx_d = '0;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
          min_d     = 8'hFF;
`endif
          state_d   = (len == '0) ? StFlush : StRun;
        end
      end
      StRun: begin
        if (hs) begin
          s1_valid_d = 1'b1;
          s1_max_d   = lane_max;
          s1_idx_d   = count_q;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
          s1_min_d   = lane_min;
`endif
          count_d    = count_q + CntOne;
          if (count_q == len_q - CntOne) state_d = StFlush;
        end
      end
      StFlush: begin
        // Stage 2 consumes the last stage-1 value on this same edge.
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d    = StIdle;
      count_d    = '0;
      max_d      = '0;
      max_idx_d  = '0;
      s1_valid_d = 1'b0;
      done_d     = 1'b0;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
      min_d      = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      count_q    <= '0;
      max_q      <= '0;
      max_idx_q  <= '0;
      s1_max_q   <= '0;
      s1_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
      min_q      <= 8'hFF;
      s1_min_q   <= 8'hFF;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      s1_max_q   <= s1_max_d;
      s1_idx_q   <= s1_idx_d;
      s1_valid_q <= s1_valid_d;
      done_q     <= done_d;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
      min_q      <= min_d;
      s1_min_q   <= s1_min_d;
`endif
    end
  end

  assign in_ready = (state_q == StRun);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign max_o    = max_q;
  assign max_idx  = max_idx_q;
  assign count    = count_q;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
  assign min_o    = min_q;
`endif

endmodule

// File: tb/tb_iob_gpio_max_seq.sv
// Self-checking bench for iob_gpio_max_seq: directed scenarios plus a randomized run against a
// word-list reference model.
module tb_iob_gpio_max_seq;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [15:0] len;
  logic        clear;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [7:0]  max_o;
  logic [15:0] max_idx;
  logic [15:0] count;
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
  logic [7:0]  min_o;
`endif

  iob_gpio_max_seq #(.DATA_W(32), .CNT_W(16)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .start    (start),
    .len      (len),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_o    (max_o),
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    .min_o    (min_o),
`endif
    .max_idx  (max_idx),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the list of accepted words, and how many of them have reached the result.
  logic [31:0] acc[$];
  int          folded = 0;
  int          m_len  = 0;
  bit          m_busy = 0;
  bit          m_flush = 0;
  bit          m_done = 0;

  initial forever begin
    @(posedge clk or negedge arst_n);
    if (!arst_n || clear) begin
      acc.delete(); folded = 0; m_busy = 0; m_flush = 0; m_done = 0;
    end else begin
      // Words accepted at earlier edges are folded into the result at this edge.
      folded = acc.size();
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          acc.delete(); folded = 0; m_len = int'(len); m_busy = 1; m_flush = (len == 0);
        end
      end else if (m_flush) begin
        m_busy = 0; m_flush = 0; m_done = 1;
      end else if (in_valid) begin
        acc.push_back(in_data);
        if (acc.size() == m_len) m_flush = 1;
      end
    end
  end

  function automatic void model_result(output logic [7:0] mx, output int idx,
                                       output logic [7:0] mn);
    logic [7:0] b;
    mx = 8'h00; idx = 0; mn = 8'hFF;
    for (int w = 0; w < folded; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = acc[w][8*k +: 8];
        if (b > mx) begin mx = b; idx = w; end
        if (b < mn) mn = b;
      end
    end
  endfunction

  bit cmp_en = 0;
  always @(negedge clk) begin
    logic [7:0] e_mx, e_mn;
    int         e_idx;
    if (arst_n && cmp_en) begin
      model_result(e_mx, e_idx, e_mn);
      chk("model in_ready", 32'(in_ready), 32'(m_busy && !m_flush));
      chk("model busy", 32'(busy), 32'(m_busy));
      chk("model done", 32'(done), 32'(m_done));
      chk("model count", 32'(count), 32'(acc.size()));
      chk("model max_o", 32'(max_o), 32'(e_mx));
      chk("model max_idx", 32'(max_idx), 32'(e_idx));
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
      chk("model min_o", 32'(min_o), 32'(e_mn));
`endif
    end
  end

  logic [31:0] wq[$];

  task automatic do_start(input int n);
    @(posedge clk); #1 start = 1'b1; len = 16'(n);
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Presents wq[0..nwords-1]; pattern bits (LSB first) gate in_valid when pat_len > 0.
  task automatic send(input logic [15:0] pat, input int pat_len, input int nwords);
    int j = 0;
    int c = 0;
    bit hs;
    while (j < nwords && c < 200) begin
      in_valid = (pat_len > 0) ? pat[c % pat_len] : 1'b1;
      in_data  = wq[j];
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) j++;
      c++;
    end
    in_valid = 1'b0;
    if (j < nwords) chk("send handshakes", 32'(j), 32'(nwords));
  endtask

  task automatic finish_check();
    @(negedge clk);
    chk("flush in_ready", 32'(in_ready), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done pulse", 32'(done), 32'd1);
    chk("busy after done", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " max_o"}, 32'(max_o), 32'd0);
    chk({tag, " max_idx"}, 32'(max_idx), 32'd0);
    chk({tag, " count"}, 32'(count), 32'd0);
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    chk({tag, " min_o"}, 32'(min_o), 32'hFF);
`endif
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; len = '0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    #2 arst_n = 1'b1;
    cmp_en = 1;

    // Basic burst.
    wq = '{32'h01020304, 32'h0A000000, 32'h000000FF, 32'h10101010};
    do_start(4);
    send(16'h0, 0, 4);
    finish_check();
    chk("t1 max_o", 32'(max_o), 32'hFF);
    chk("t1 max_idx", 32'(max_idx), 32'd2);
    chk("t1 count", 32'(count), 32'd4);
`ifdef IOB_GPIO_MAX_SEQ_MIN_EN
    chk("t1 min_o", 32'(min_o), 32'h00);
`endif
    @(negedge clk);
    chk("t1 done low", 32'(done), 32'd0);

    // Tie keeps the earliest index.
    wq = '{32'h00000050, 32'h50000000, 32'h00500000};
    do_start(3);
    send(16'h0, 0, 3);
    finish_check();
    chk("tie max_o", 32'(max_o), 32'h50);
    chk("tie max_idx", 32'(max_idx), 32'd0);

    // Gaps in in_valid: 1,0,0,1,0,1.
    wq = '{32'h11223344, 32'h00000099, 32'h05060708};
    do_start(3);
    send(16'b101001, 6, 3);
    finish_check();
    chk("gap count", 32'(count), 32'd3);
    chk("gap max_o", 32'(max_o), 32'h99);
    chk("gap max_idx", 32'(max_idx), 32'd1);

    // Empty burst.
    do_start(0);
    @(negedge clk);
    chk("len0 busy", 32'(busy), 32'd1);
    chk("len0 done early", 32'(done), 32'd0);
    @(negedge clk);
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy low", 32'(busy), 32'd0);
    chk("len0 max_o", 32'(max_o), 32'd0);
    chk("len0 count", 32'(count), 32'd0);
    @(negedge clk);
    chk("len0 done low", 32'(done), 32'd0);

    // Abort with clear; a start while busy must not resample len.
    wq = '{32'h000000AA, 32'h0000BB00, 32'hCC000000};
    do_start(8);
    start = 1'b1; len = 16'd2;
    @(posedge clk); #1 start = 1'b0;
    send(16'h0, 0, 3);
    @(negedge clk);
    chk("abort still ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    chk("abort max_o", 32'(max_o), 32'd0);
    chk("abort count", 32'(count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 32'd0);
    end

    // Asynchronous reset mid-burst.
    wq = '{32'h00330000, 32'h44000000};
    do_start(5);
    send(16'h0, 0, 2);
    #2 arst_n = 1'b0;
    #1 check_reset_values("async reset");
    @(negedge clk); #1 arst_n = 1'b1;
    wq = '{32'h7F000000};
    do_start(1);
    send(16'h0, 0, 1);
    finish_check();
    chk("post-reset max_o", 32'(max_o), 32'h7F);
    chk("post-reset max_idx", 32'(max_idx), 32'd0);
    chk("post-reset count", 32'(count), 32'd1);

    // Randomized traffic, checked every cycle by the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(99) < 12);
      len      = 16'($urandom_range(6));
      clear    = ($urandom_range(99) < 2);
      in_valid = ($urandom_range(99) < 70);
      if ($urandom_range(1) == 0) in_data = $urandom;
      else begin
        for (int k = 0; k < 4; k++) in_data[8*k +: 8] = 8'($urandom_range(3) * 8'h20);
      end
    end
    start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
